// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code collapser: folds E0/F0 prefixes into {ext,brk,code} events queued in a FWFT FIFO.
// Define PS2_PAUSE_FILTER_EN to fold the 8-byte E1 Pause sequence into a single {1,0,77} event.
module ps2_scan_decoder #(
    parameter int          DEPTH       = 8,
    parameter int          AW          = 3,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scan_tick,
    input  logic [7:0]    scan_code,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [7:0]    ev_code,
    output logic          ev_ext,
    output logic          ev_brk,
    output logic [AW:0]   ev_count,
    output logic          overflow,
    output logic          seq_err
);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef enum logic [2:0] {
        IDLE, EXT, BRK,
`ifdef PS2_PAUSE_FILTER_EN
        EXT_BRK, PAUSE
`else
        EXT_BRK
`endif
    } state_t;

    state_t      state;
    logic [19:0] tcnt;
`ifdef PS2_PAUSE_FILTER_EN
    logic [2:0]  skip;
`endif

    logic is_e0, is_f0, is_e1, is_pfx;
    assign is_e0  = (scan_code == 8'hE0);
    assign is_f0  = (scan_code == 8'hF0);
    assign is_e1  = (scan_code == 8'hE1);
    assign is_pfx = is_e0 | is_f0;

    // Event decode is combinational so the word lands in the FIFO on the final byte's edge
    logic push;
    ev_t  push_word;
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (scan_tick) begin
            case (state)
                IDLE: begin
`ifdef PS2_PAUSE_FILTER_EN
                    push = !is_pfx && !is_e1;
`else
                    push = !is_pfx;
`endif
                    push_word = '{ext: 1'b0, brk: 1'b0, code: scan_code};
                end
                EXT: begin
                    push      = !is_pfx;
                    push_word = '{ext: 1'b1, brk: 1'b0, code: scan_code};
                end
                BRK: begin
                    push      = !is_pfx;
                    push_word = '{ext: 1'b0, brk: 1'b1, code: scan_code};
                end
                EXT_BRK: begin
                    push      = !is_pfx;
                    push_word = '{ext: 1'b1, brk: 1'b1, code: scan_code};
                end
`ifdef PS2_PAUSE_FILTER_EN
                PAUSE: begin
                    push      = (skip == 3'd1);
                    push_word = '{ext: 1'b1, brk: 1'b0, code: 8'h77};
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tcnt    <= '0;
            seq_err <= 1'b0;
`ifdef PS2_PAUSE_FILTER_EN
            skip    <= '0;
`endif
        end else begin
            seq_err <= 1'b0;
            if (scan_tick) begin
                // A byte arriving on the expiry cycle takes priority over the timeout
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (is_e0)      state <= EXT;
                        else if (is_f0) state <= BRK;
`ifdef PS2_PAUSE_FILTER_EN
                        else if (is_e1) begin
                            state <= PAUSE;
                            skip  <= 3'd7;
                        end
`endif
                    end
                    EXT: begin
                        if (is_f0)       state <= EXT_BRK;
                        else if (!is_e0) state <= IDLE;
                    end
                    BRK: begin
                        if (is_e0)       state <= EXT_BRK;
                        else if (!is_f0) state <= IDLE;
                    end
                    EXT_BRK: begin
                        if (!is_pfx) state <= IDLE;
                    end
`ifdef PS2_PAUSE_FILTER_EN
                    PAUSE: begin
                        skip <= skip - 3'd1;
                        if (skip == 3'd1) state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TIMEOUT_CYC - 20'd1) begin
                state   <= IDLE;
                seq_err <= 1'b1;
                tcnt    <= '0;
            end else begin
                tcnt <= tcnt + 20'd1;
            end
        end
    end

    ev_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, wr_en;

    assign ev_valid = (ev_count != '0);
    assign full     = (ev_count == (AW+1)'(DEPTH));
    assign pop      = ev_valid & ev_ready;
    // When full, a same-cycle pop frees the slot the write reuses
    assign wr_en    = push & (!full | pop);

    assign ev_ext  = mem[rd_ptr].ext;
    assign ev_brk  = mem[rd_ptr].brk;
    assign ev_code = mem[rd_ptr].code;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & full & !pop;
            if (wr_en) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      ev_count <= ev_count + (AW+1)'(1);
            else if (pop && !wr_en) ev_count <= ev_count - (AW+1)'(1);
        end
    end

endmodule
